// File: rtl/cayde_wb_arbiter.sv
// Writeback arbiter for the cayde regfile's single write port: round-robin ALU/LSU
// arbitration, a registered write stage, and a RAW-hazard scoreboard for issue.
module cayde_wb_arbiter #(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int NREG = 32,
    parameter int CW   = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid_in,
    input  logic [AW-1:0]   alu_rd_in,
    input  logic [XLEN-1:0] alu_data_in,
    output logic            alu_ready_out,
    input  logic            lsu_valid_in,
    input  logic [AW-1:0]   lsu_rd_in,
    input  logic [XLEN-1:0] lsu_data_in,
    output logic            lsu_ready_out,
    input  logic            iss_valid_in,
    input  logic [AW-1:0]   iss_rd_in,
    input  logic [AW-1:0]   rs1_in,
    input  logic [AW-1:0]   rs2_in,
    input  logic            flush_in,
    output logic            busy_rs1_out,
    output logic            busy_rs2_out,
    output logic [AW-1:0]   waddr_out,
    output logic [XLEN-1:0] wdata_out,
    output logic            wen_out,
    output logic [CW-1:0]   stall_cnt_out
);

    typedef enum logic {SRC_ALU = 1'b0, SRC_LSU = 1'b1} src_e;

    src_e            last_q, last_d;
    logic            wen_q, wen_d;
    logic [AW-1:0]   waddr_q, waddr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [NREG-1:0] pending_q, pending_d;
    logic [CW-1:0]   stall_q, stall_d;
    logic            alu_gnt, lsu_gnt, stalled;

    // On a conflict the side that did not win last time takes the port.
    always_comb begin
        alu_gnt = alu_valid_in & (~lsu_valid_in | (last_q == SRC_LSU));
        lsu_gnt = lsu_valid_in & ~alu_gnt;
        stalled = (alu_valid_in & ~alu_gnt) | (lsu_valid_in & ~lsu_gnt);
    end

    always_comb begin
        last_d  = last_q;
        wen_d   = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (alu_gnt) begin
            last_d  = SRC_ALU;
            wen_d   = (alu_rd_in != '0);
            waddr_d = alu_rd_in;
            wdata_d = alu_data_in;
        end else if (lsu_gnt) begin
            last_d  = SRC_LSU;
            wen_d   = (lsu_rd_in != '0);
            waddr_d = lsu_rd_in;
            wdata_d = lsu_data_in;
        end
    end

    // Ordering matters: a new issue beats the retiring write, flush beats both.
    always_comb begin
        pending_d = pending_q;
        if (wen_q)
            pending_d[waddr_q] = 1'b0;
        if (iss_valid_in && iss_rd_in != '0)
            pending_d[iss_rd_in] = 1'b1;
        if (flush_in)
            pending_d = '0;
        pending_d[0] = 1'b0;
    end

    always_comb begin
        stall_d = stall_q;
        if (stalled && stall_q != {CW{1'b1}})
            stall_d = stall_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q    <= SRC_LSU;
            wen_q     <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            pending_q <= '0;
            stall_q   <= '0;
        end else begin
            last_q    <= last_d;
            wen_q     <= wen_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            pending_q <= pending_d;
            stall_q   <= stall_d;
        end
    end

    assign alu_ready_out = alu_gnt;
    assign lsu_ready_out = lsu_gnt;
    assign busy_rs1_out  = pending_q[rs1_in];
    assign busy_rs2_out  = pending_q[rs2_in];
    assign wen_out       = wen_q;
    assign waddr_out     = waddr_q;
    assign wdata_out     = wdata_q;
    assign stall_cnt_out = stall_q;

endmodule

// File: tb/tb_cayde_wb_arbiter.sv
// Directed bench for cayde_wb_arbiter: a per-cycle vector table plus hand-written
// sequences for conflict alternation, async reset and counter saturation.
module tb_cayde_wb_arbiter;
    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NREG = 32;
    localparam int CW   = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            alu_valid_in, lsu_valid_in, iss_valid_in, flush_in;
    logic [AW-1:0]   alu_rd_in, lsu_rd_in, iss_rd_in, rs1_in, rs2_in;
    logic [XLEN-1:0] alu_data_in, lsu_data_in;
    logic            alu_ready_out, lsu_ready_out, busy_rs1_out, busy_rs2_out, wen_out;
    logic [AW-1:0]   waddr_out;
    logic [XLEN-1:0] wdata_out;
    logic [CW-1:0]   stall_cnt_out;

    int tests = 0;
    int fails = 0;

    cayde_wb_arbiter #(.XLEN(XLEN), .AW(AW), .NREG(NREG), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .alu_valid_in(alu_valid_in), .alu_rd_in(alu_rd_in), .alu_data_in(alu_data_in),
        .alu_ready_out(alu_ready_out),
        .lsu_valid_in(lsu_valid_in), .lsu_rd_in(lsu_rd_in), .lsu_data_in(lsu_data_in),
        .lsu_ready_out(lsu_ready_out),
        .iss_valid_in(iss_valid_in), .iss_rd_in(iss_rd_in),
        .rs1_in(rs1_in), .rs2_in(rs2_in), .flush_in(flush_in),
        .busy_rs1_out(busy_rs1_out), .busy_rs2_out(busy_rs2_out),
        .waddr_out(waddr_out), .wdata_out(wdata_out), .wen_out(wen_out),
        .stall_cnt_out(stall_cnt_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic av; logic [AW-1:0] ard; logic [XLEN-1:0] ad;
        logic lv; logic [AW-1:0] lrd; logic [XLEN-1:0] ld;
        logic iv; logic [AW-1:0] ird;
        logic [AW-1:0] r1; logic [AW-1:0] r2; logic fl;
        logic ar; logic lr; logic b1; logic b2;
        logic wen; logic [AW-1:0] wa; logic [XLEN-1:0] wd; logic [CW-1:0] sc;
    } vec_t;

    vec_t vecs[27];

    function automatic vec_t mk(
        input logic av, input int ard, input logic [31:0] ad,
        input logic lv, input int lrd, input logic [31:0] ld,
        input logic iv, input int ird, input int r1, input int r2, input logic fl,
        input logic ar, input logic lr, input logic b1, input logic b2,
        input logic wen, input int wa, input logic [31:0] wd, input int sc);
        vec_t v;
        v.av = av; v.ard = AW'(ard); v.ad = ad;
        v.lv = lv; v.lrd = AW'(lrd); v.ld = ld;
        v.iv = iv; v.ird = AW'(ird); v.r1 = AW'(r1); v.r2 = AW'(r2); v.fl = fl;
        v.ar = ar; v.lr = lr; v.b1 = b1; v.b2 = b2;
        v.wen = wen; v.wa = AW'(wa); v.wd = wd; v.sc = CW'(sc);
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic av, input int ard, input logic [31:0] ad,
                         input logic lv, input int lrd, input logic [31:0] ld);
        alu_valid_in = av; alu_rd_in = AW'(ard); alu_data_in = ad;
        lsu_valid_in = lv; lsu_rd_in = AW'(lrd); lsu_data_in = ld;
    endtask

    task automatic idle_inputs();
        drive(1'b0, 0, 32'h0, 1'b0, 0, 32'h0);
        iss_valid_in = 1'b0; iss_rd_in = '0; rs1_in = '0; rs2_in = '0; flush_in = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Cycle-by-cycle expectations; outputs are sampled at negedge of each row's cycle.
        //               av ard ad             lv lrd ld            iv ird r1 r2 fl  ar lr b1 b2 wen wa wd           sc
        vecs[0]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  0, 0, 0,  0, 0, 0, 0, 0, 0,  32'h0,        0);
        vecs[1]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  0, 0, 0,  0, 0, 0, 0, 0, 0,  32'h0,        0);
        vecs[2]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 32'h0,        0, 0,  0, 0, 0,  1, 0, 0, 0, 0, 0,  32'h0,        0);
        vecs[3]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  0, 0, 0,  0, 0, 0, 0, 1, 5,  32'hDEADBEEF, 0);
        vecs[4]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  0, 0, 0,  0, 0, 0, 0, 0, 5,  32'hDEADBEEF, 0);
        vecs[5]  = mk(1, 3, 32'h11,       1, 4, 32'h22,       0, 0,  0, 0, 0,  0, 1, 0, 0, 0, 5,  32'hDEADBEEF, 0);
        vecs[6]  = mk(1, 3, 32'h11,       0, 0, 32'h0,        0, 0,  0, 0, 0,  1, 0, 0, 0, 1, 4,  32'h22,       1);
        vecs[7]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  0, 0, 0,  0, 0, 0, 0, 1, 3,  32'h11,       1);
        vecs[8]  = mk(0, 0, 32'h0,        1, 0, 32'hFFFFFFFF, 0, 0,  0, 0, 0,  0, 1, 0, 0, 0, 3,  32'h11,       1);
        vecs[9]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 0,  0, 0, 0,  0, 0, 0, 0, 0, 0,  32'hFFFFFFFF, 1);
        vecs[10] = mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  0, 0, 0,  0, 0, 0, 0, 0, 0,  32'hFFFFFFFF, 1);
        vecs[11] = mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 7,  7, 0, 0,  0, 0, 0, 0, 0, 0,  32'hFFFFFFFF, 1);
        vecs[12] = mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  7, 0, 0,  0, 0, 1, 0, 0, 0,  32'hFFFFFFFF, 1);
        vecs[13] = mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  7, 0, 0,  0, 0, 1, 0, 0, 0,  32'hFFFFFFFF, 1);
        vecs[14] = mk(0, 0, 32'h0,        1, 7, 32'h77,       0, 0,  7, 0, 0,  0, 1, 1, 0, 0, 0,  32'hFFFFFFFF, 1);
        vecs[15] = mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  7, 0, 0,  0, 0, 1, 0, 1, 7,  32'h77,       1);
        vecs[16] = mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  7, 0, 0,  0, 0, 0, 0, 0, 7,  32'h77,       1);
        vecs[17] = mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 8,  8, 0, 0,  0, 0, 0, 0, 0, 7,  32'h77,       1);
        vecs[18] = mk(0, 0, 32'h0,        1, 8, 32'h88,       0, 0,  8, 0, 0,  0, 1, 1, 0, 0, 7,  32'h77,       1);
        vecs[19] = mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 8,  8, 0, 0,  0, 0, 1, 0, 1, 8,  32'h88,       1);
        vecs[20] = mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  8, 8, 0,  0, 0, 1, 1, 0, 8,  32'h88,       1);
        vecs[21] = mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  8, 0, 0,  0, 0, 1, 0, 0, 8,  32'h88,       1);
        vecs[22] = mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 9,  9, 10, 0, 0, 0, 0, 0, 0, 8,  32'h88,       1);
        vecs[23] = mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 10, 9, 10, 0, 0, 0, 1, 0, 0, 8,  32'h88,       1);
        vecs[24] = mk(1, 12, 32'hC,       0, 0, 32'h0,        1, 11, 9, 10, 1, 1, 0, 1, 1, 0, 8,  32'h88,       1);
        vecs[25] = mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  11, 8, 0, 0, 0, 0, 0, 1, 12, 32'hC,        1);
        vecs[26] = mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  9, 10, 0, 0, 0, 0, 0, 0, 12, 32'hC,        1);

        do_reset();
        #1;
        chk("rst_wen", 0, 32'(wen_out), 32'h0);
        chk("rst_waddr", 0, 32'(waddr_out), 32'h0);
        chk("rst_wdata", 0, wdata_out, 32'h0);
        chk("rst_stall", 0, 32'(stall_cnt_out), 32'h0);

        for (int i = 0; i < 27; i++) begin
            drive(vecs[i].av, int'(vecs[i].ard), vecs[i].ad, vecs[i].lv, int'(vecs[i].lrd), vecs[i].ld);
            iss_valid_in = vecs[i].iv; iss_rd_in = vecs[i].ird;
            rs1_in = vecs[i].r1; rs2_in = vecs[i].r2; flush_in = vecs[i].fl;
            @(negedge clk);
            chk("alu_ready", i, 32'(alu_ready_out), 32'(vecs[i].ar));
            chk("lsu_ready", i, 32'(lsu_ready_out), 32'(vecs[i].lr));
            chk("busy_rs1", i, 32'(busy_rs1_out), 32'(vecs[i].b1));
            chk("busy_rs2", i, 32'(busy_rs2_out), 32'(vecs[i].b2));
            chk("wen", i, 32'(wen_out), 32'(vecs[i].wen));
            chk("waddr", i, 32'(waddr_out), 32'(vecs[i].wa));
            chk("wdata", i, wdata_out, vecs[i].wd);
            chk("stall_cnt", i, 32'(stall_cnt_out), 32'(vecs[i].sc));
            next_cycle();
        end

        // Collision straight out of reset: ALU first, then alternation.
        do_reset();
        drive(1'b1, 3, 32'h11, 1'b1, 4, 32'h22);
        @(negedge clk);
        chk("col0_alu_rdy", 0, 32'(alu_ready_out), 32'h1);
        chk("col0_lsu_rdy", 0, 32'(lsu_ready_out), 32'h0);
        next_cycle();
        drive(1'b0, 0, 32'h0, 1'b1, 4, 32'h22);
        @(negedge clk);
        chk("col1_lsu_rdy", 1, 32'(lsu_ready_out), 32'h1);
        chk("col1_waddr", 1, 32'(waddr_out), 32'h3);
        chk("col1_wdata", 1, wdata_out, 32'h11);
        chk("col1_stall", 1, 32'(stall_cnt_out), 32'h1);
        next_cycle();
        drive(1'b1, 6, 32'h66, 1'b1, 9, 32'h99);
        @(negedge clk);
        chk("col2_alu_rdy", 2, 32'(alu_ready_out), 32'h1);
        chk("col2_lsu_rdy", 2, 32'(lsu_ready_out), 32'h0);
        chk("col2_waddr", 2, 32'(waddr_out), 32'h4);
        chk("col2_wdata", 2, wdata_out, 32'h22);
        next_cycle();
        drive(1'b1, 13, 32'hDD, 1'b1, 9, 32'h99);
        @(negedge clk);
        chk("col3_alu_rdy", 3, 32'(alu_ready_out), 32'h0);
        chk("col3_lsu_rdy", 3, 32'(lsu_ready_out), 32'h1);
        chk("col3_waddr", 3, 32'(waddr_out), 32'h6);
        chk("col3_stall", 3, 32'(stall_cnt_out), 32'h2);
        next_cycle();
        drive(1'b0, 0, 32'h0, 1'b0, 0, 32'h0);
        @(negedge clk);
        chk("col4_waddr", 4, 32'(waddr_out), 32'h9);
        chk("col4_wen", 4, 32'(wen_out), 32'h1);
        chk("col4_stall", 4, 32'(stall_cnt_out), 32'h3);

        // Async reset while a write is on the port.
        next_cycle();
        drive(1'b1, 5, 32'hABCD, 1'b0, 0, 32'h0);
        iss_valid_in = 1'b1; iss_rd_in = 5'd5;
        next_cycle();
        idle_inputs();
        rs1_in = 5'd5;
        #1;
        chk("pre_rst_wen", 0, 32'(wen_out), 32'h1);
        chk("pre_rst_busy", 0, 32'(busy_rs1_out), 32'h1);
        rst = 1'b0;
        #1;
        chk("async_rst_wen", 0, 32'(wen_out), 32'h0);
        chk("async_rst_waddr", 0, 32'(waddr_out), 32'h0);
        chk("async_rst_busy", 0, 32'(busy_rs1_out), 32'h0);
        chk("async_rst_stall", 0, 32'(stall_cnt_out), 32'h0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Saturation: every collision cycle has one loser.
        drive(1'b1, 1, 32'h1, 1'b1, 2, 32'h2);
        repeat (20) next_cycle();
        @(negedge clk);
        chk("stall_sat", 0, 32'(stall_cnt_out), 32'hF);
        next_cycle();
        @(negedge clk);
        chk("stall_sat_hold", 0, 32'(stall_cnt_out), 32'hF);
        idle_inputs();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end
endmodule
